// File: rtl/shift_sequencer.sv
// Sequences a shared extend/shift unit: loads the extended operand, then
// walks the accumulator through shift-by-4 and shift-by-1 steps to Amt.
module shift_sequencer #(
    parameter int STEP4_EN = 1
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [1:0]  Src,
    input  logic        Left,
    input  logic [3:0]  Amt,
    input  logic [15:0] Ext_ALUOut,
    input  logic [15:0] O,
    output logic [1:0]  ShifterInput,
    output logic [1:0]  ShiftAmount,
    output logic        ShifterLeft,
    output logic [15:0] ALUOut_fb,
    output logic [15:0] Result,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP4,
        S_STEP1,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q;
    logic [3:0]  rem_q, rem_d;
    logic [1:0]  src_q;
    logic        left_q;
    logic        busy_q;
    logic        done_q;

    // Coarse steps first, then single steps for the remainder.
    function automatic state_t pick_step(input logic [3:0] r);
        if (STEP4_EN != 0 && r >= 4'd4) return S_STEP4;
        else if (r != 4'd0)             return S_STEP1;
        else                            return S_DONE;
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_LOAD;
                    rem_d   = Amt;
                end
            end
            S_LOAD: state_d = pick_step(rem_q);
            S_STEP4: begin
                rem_d   = rem_q - 4'd4;
                state_d = pick_step(rem_d);
            end
            S_STEP1: begin
                rem_d   = rem_q - 4'd1;
                state_d = pick_step(rem_d);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= 16'h0000;
            rem_q   <= 4'd0;
            src_q   <= 2'b00;
            left_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            if (state_q == S_IDLE && Start) begin
                src_q  <= Src;
                left_q <= Left;
            end
            if (state_q == S_LOAD || state_q == S_STEP4 ||
                state_q == S_STEP1) begin
                acc_q <= O;
            end
        end
    end

    // Shift-unit controls are Moore decodes of the state register.
    always_comb begin
        ShifterInput = 2'b00;
        ShiftAmount  = 2'b10;
        ShifterLeft  = 1'b0;
        ALUOut_fb    = Ext_ALUOut;
        case (state_q)
            S_LOAD: begin
                ShifterInput = src_q;
                ShifterLeft  = left_q;
            end
            S_STEP4: begin
                ShifterInput = 2'b11;
                ShiftAmount  = 2'b11;
                ShifterLeft  = left_q;
                ALUOut_fb    = acc_q;
            end
            S_STEP1: begin
                ShifterInput = 2'b11;
                ShiftAmount  = 2'b00;
                ShifterLeft  = left_q;
                ALUOut_fb    = acc_q;
            end
            default: ;
        endcase
    end

    assign Result = acc_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: both step modes run side by side against a
// shift-unit model and an arithmetic reference of the final result.
module tb_shift_sequencer;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Src = 2'b00;
    logic        Left = 1'b0;
    logic [3:0]  Amt = 4'd0;
    logic [15:0] IR = 16'h0;
    logic [15:0] RegA = 16'h0;
    logic [15:0] ExtALU = 16'h0;

    logic [1:0]  si4, sa4, si1, sa1;
    logic        sl4, sl1, busy4, busy1, done4, done1;
    logic [15:0] fb4, fb1, res4, res1, O4, O1;

    int checks = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    // Environment model of the shared extend/shift unit.
    function automatic logic [15:0] shunit(
        input logic [1:0] si, input logic [1:0] sa, input logic sl,
        input logic [15:0] ir, input logic [15:0] ra, input logic [15:0] fb);
        logic [15:0] op;
        int n;
        case (si)
            2'b00:   op = {12'h000, ir[3:0]};
            2'b01:   op = {{8{ir[7]}}, ir[7:0]};
            2'b10:   op = ra;
            default: op = fb;
        endcase
        case (sa)
            2'b00:   n = 1;
            2'b11:   n = 4;
            default: n = 0;
        endcase
        return sl ? (op << n) : (op >> n);
    endfunction

    assign O4 = shunit(si4, sa4, sl4, IR, RegA, fb4);
    assign O1 = shunit(si1, sa1, sl1, IR, RegA, fb1);

    shift_sequencer #(.STEP4_EN(1)) dut4 (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Src(Src),
        .Left(Left), .Amt(Amt), .Ext_ALUOut(ExtALU), .O(O4),
        .ShifterInput(si4), .ShiftAmount(sa4), .ShifterLeft(sl4),
        .ALUOut_fb(fb4), .Result(res4), .Busy(busy4), .Done(done4)
    );

    shift_sequencer #(.STEP4_EN(0)) dut1 (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Src(Src),
        .Left(Left), .Amt(Amt), .Ext_ALUOut(ExtALU), .O(O1),
        .ShifterInput(si1), .ShiftAmount(sa1), .ShifterLeft(sl1),
        .ALUOut_fb(fb1), .Result(res1), .Busy(busy1), .Done(done1)
    );

    // Reference: the whole operation is one extend plus one shift.
    function automatic logic [15:0] ref_result(
        input logic [1:0] s, input logic l, input logic [3:0] a,
        input logic [15:0] ir, input logic [15:0] ra, input logic [15:0] ext);
        logic [31:0] v;
        if (s == 2'd0)      v = 32'(ir[3:0]);
        else if (s == 2'd1) v = 32'($signed(ir[7:0])) & 32'hffff;
        else if (s == 2'd2) v = 32'(ra);
        else                v = 32'(ext);
        v = l ? (v << a) : (v >> a);
        return v[15:0];
    endfunction

    function automatic int ref_lat(input int step4, input int a);
        return step4 ? 2 + a / 4 + a % 4 : 2 + a;
    endfunction

    // Runs one request; latency counts the Start-sampling edge as edge 1.
    task automatic run_op(
        input logic [1:0] s, input logic l, input logic [3:0] a,
        input logic [15:0] ir, input logic [15:0] ra, input logic [15:0] ext,
        output int l4, output int l1, output int w4, output int w1,
        output logic [15:0] r4, output logic [15:0] r1);
        int last;
        l4 = 0; l1 = 0; w4 = 0; w1 = 0;
        @(negedge CLK);
        Src = s; Left = l; Amt = a; IR = ir; RegA = ra; ExtALU = ext;
        Start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        for (int n = 2; n <= 40; n++) begin
            @(posedge CLK);
            #1;
            if (done4) begin w4++; if (l4 == 0) l4 = n; end
            if (done1) begin w1++; if (l1 == 0) l1 = n; end
            if (n == 2) begin
                IR = 16'($urandom); RegA = 16'($urandom);
                ExtALU = 16'($urandom);
            end
            last = (l4 > l1) ? l4 : l1;
            if (l4 != 0 && l1 != 0 && n > last) break;
        end
        r4 = res4; r1 = res1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || res4 !== 16'h0 ||
            si4 !== 2'b00 || sa4 !== 2'b10 || sl4 !== 1'b0) begin
            errs++;
            $display("FAIL reset4: busy=%b done=%b res=%h si=%b sa=%b sl=%b",
                     busy4, done4, res4, si4, sa4, sl4);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 16'h0 ||
            si1 !== 2'b00 || sa1 !== 2'b10 || sl1 !== 1'b0) begin
            errs++;
            $display("FAIL reset1: busy=%b done=%b res=%h si=%b sa=%b sl=%b",
                     busy1, done1, res1, si1, sa1, sl1);
        end
        ExtALU = 16'h5a3c;
        #1;
        checks++;
        if (fb4 !== 16'h5a3c) begin
            errs++;
            $display("FAIL idle_fb: got %h want 5a3c", fb4);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    task automatic test_directed;
        int l4, l1, w4, w1;
        logic [15:0] r4, r1;
        run_op(2'b01, 1'b0, 4'd1, 16'h0081, 16'h0, 16'h0,
               l4, l1, w4, w1, r4, r1);
        checks++;
        if (r4 !== 16'h7fc0 || l4 != 3 || r1 !== 16'h7fc0 || l1 != 3) begin
            errs++;
            $display("FAIL sext_r1: res %h/%h lat %0d/%0d want 7fc0 lat 3",
                     r4, r1, l4, l1);
        end
        run_op(2'b10, 1'b1, 4'd5, 16'h0, 16'h1111, 16'h0,
               l4, l1, w4, w1, r4, r1);
        checks++;
        if (r4 !== 16'h2220 || l4 != 4 || r1 !== 16'h2220 || l1 != 7) begin
            errs++;
            $display("FAIL rega_l5: res %h/%h lat %0d/%0d want 2220 lat 4/7",
                     r4, r1, l4, l1);
        end
        run_op(2'b11, 1'b0, 4'd15, 16'h0, 16'h0, 16'h8000,
               l4, l1, w4, w1, r4, r1);
        checks++;
        if (r4 !== 16'h0001 || l4 != 8 || r1 !== 16'h0001 || l1 != 17) begin
            errs++;
            $display("FAIL ext_r15: res %h/%h lat %0d/%0d want 0001 lat 8/17",
                     r4, r1, l4, l1);
        end
        checks++;
        if (w4 != 1 || w1 != 1) begin
            errs++;
            $display("FAIL done_width: got %0d/%0d want 1", w4, w1);
        end
    endtask

    task automatic test_hold_start;
        @(negedge CLK);
        Src = 2'b00; Left = 1'b1; Amt = 4'd0; IR = 16'h0001;
        Start = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (busy4 !== 1'b1 || done4 !== 1'b0 || sa4 !== 2'b10 ||
            si4 !== 2'b00 || sl4 !== 1'b1) begin
            errs++;
            $display("FAIL load_ctl: busy=%b done=%b sa=%b si=%b sl=%b",
                     busy4, done4, sa4, si4, sl4);
        end
        @(posedge CLK); #1;
        checks++;
        if (done4 !== 1'b1 || done1 !== 1'b1 || res4 !== 16'h0001 ||
            res1 !== 16'h0001 || sl4 !== 1'b0) begin
            errs++;
            $display("FAIL amt0: done=%b/%b res=%h/%h sl=%b want 1 0001 0",
                     done4, done1, res4, res1, sl4);
        end
        @(posedge CLK); #1;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || busy1 !== 1'b0) begin
            errs++;
            $display("FAIL done_ignores_start: busy=%b/%b done=%b want 0",
                     busy4, busy1, done4);
        end
        @(posedge CLK); #1;
        checks++;
        if (busy4 !== 1'b1 || busy1 !== 1'b1) begin
            errs++;
            $display("FAIL reaccept: busy=%b/%b want 1", busy4, busy1);
        end
        @(negedge CLK);
        Start = 1'b0;
        for (int n = 0; n < 40 && (busy4 || busy1); n++) @(negedge CLK);
        checks++;
        if (busy4 !== 1'b0 || busy1 !== 1'b0) begin
            errs++;
            $display("FAIL drain_timeout: busy=%b/%b want 0", busy4, busy1);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge CLK);
        Src = 2'b11; Left = 1'b0; Amt = 4'd15; ExtALU = 16'hf0f0;
        Start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (busy4 !== 1'b1 || si4 !== 2'b11 || sa4 !== 2'b00) begin
            errs++;
            $display("FAIL pre_reset_step1: busy=%b si=%b sa=%b want 1 11 00",
                     busy4, si4, sa4);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (busy4 !== 1'b0 || busy1 !== 1'b0 || res4 !== 16'h0 ||
            res1 !== 16'h0 || done4 !== 1'b0 || sa4 !== 2'b10 ||
            si4 !== 2'b00 || sl4 !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: busy=%b/%b res=%h/%h done=%b sa=%b",
                     busy4, busy1, res4, res1, done4, sa4);
        end
        seen = 0;
        repeat (2) begin
            @(posedge CLK); #1;
            if (done4 || done1 || busy4 || busy1) seen++;
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        Src = 2'b10; Left = 1'b1; Amt = 4'd3; RegA = 16'h00ff;
        Start = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (busy4 !== 1'b1 || busy1 !== 1'b1 || seen != 0) begin
            errs++;
            $display("FAIL first_edge_accept: busy=%b/%b stray=%0d",
                     busy4, busy1, seen);
        end
        @(negedge CLK);
        Start = 1'b0;
        for (int n = 0; n < 40 && (busy4 || busy1); n++) @(negedge CLK);
        checks++;
        if (res4 !== 16'h07f8 || res1 !== 16'h07f8 || busy4 || busy1) begin
            errs++;
            $display("FAIL post_reset_op: res=%h/%h want 07f8", res4, res1);
        end
    endtask

    task automatic test_random;
        int l4, l1, w4, w1;
        logic [15:0] r4, r1, exp, ir, ra, ext;
        logic [1:0] s;
        logic l;
        logic [3:0] a;
        for (int i = 0; i < 24; i++) begin
            s = 2'($urandom); l = 1'($urandom); a = 4'($urandom);
            ir = 16'($urandom); ra = 16'($urandom); ext = 16'($urandom);
            exp = ref_result(s, l, a, ir, ra, ext);
            run_op(s, l, a, ir, ra, ext, l4, l1, w4, w1, r4, r1);
            checks++;
            if (r4 !== exp || r1 !== exp) begin
                errs++;
                $display("FAIL rand_res[%0d]: src=%0d l=%b amt=%0d got %h/%h want %h",
                         i, s, l, a, r4, r1, exp);
            end
            checks++;
            if (l4 != ref_lat(1, int'(a)) || l1 != ref_lat(0, int'(a))) begin
                errs++;
                $display("FAIL rand_lat[%0d]: amt=%0d got %0d/%0d want %0d/%0d",
                         i, a, l4, l1, ref_lat(1, int'(a)), ref_lat(0, int'(a)));
            end
            checks++;
            if (w4 != 1 || w1 != 1) begin
                errs++;
                $display("FAIL rand_width[%0d]: got %0d/%0d want 1", i, w4, w1);
            end
            repeat (3) begin
                @(negedge CLK);
                IR = 16'($urandom); RegA = 16'($urandom);
                ExtALU = 16'($urandom);
            end
            checks++;
            if (res4 !== exp || res1 !== exp) begin
                errs++;
                $display("FAIL rand_hold[%0d]: got %h/%h want %h",
                         i, res4, res1, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_hold_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs);
        $finish;
    end

endmodule
